// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard-based RAW stall and redirect flush generator
// for the IF/ID and ID/IX pipeline registers.
module hazard_ctrl #(
  parameter int WB_DIST     = 3,
  parameter int FLUSH_EXTRA = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_write_to_reg,
  input  logic [4:0]  id_dest,
  input  logic        ix_redirect,
  output logic        stall,
  output logic        flush,
  output logic        issue,
  output logic [31:0] busy_vec,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  localparam logic [1:0] SetVal    = 2'(WB_DIST - 1);
  localparam logic [1:0] FlushLoad = 2'(FLUSH_EXTRA);

  logic [1:0]  cnt_q [32];
  logic [1:0]  cnt_d [32];
  logic [1:0]  flushHold_q;
  logic [1:0]  flushHold_d;
  logic [15:0] stallCount_q;
  logic [15:0] stallCount_d;
  logic [15:0] flushCount_q;
  logic [15:0] flushCount_d;
  logic        haz;

  // A register is busy while its countdown has not yet reached the regfile.
  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < 32; r++) begin
      busy_vec[r] = (cnt_q[r] != 2'd0);
    end
  end

  // Hazard detection and stall/flush/issue decisions; flush beats stall.
  always_comb begin
    haz   = id_valid & ((id_uses_rs & busy_vec[id_rs]) |
                        (id_uses_rt & busy_vec[id_rt]));
    flush = ix_redirect | (flushHold_q != 2'd0);
    stall = haz & ~flush;
    issue = id_valid & ~haz & ~flush;
  end

  // Scoreboard next state: a new issuing write reloads, otherwise count down.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = 2'd0;
      end else if (issue && id_write_to_reg && (id_dest == 5'(r))) begin
        cnt_d[r] = SetVal;
      end else if (cnt_q[r] != 2'd0) begin
        cnt_d[r] = cnt_q[r] - 2'd1;
      end
    end
  end

  // Flush hold reloads on every redirect so overlapping redirects extend it.
  always_comb begin
    flushHold_d = flushHold_q;
    if (ix_redirect) begin
      flushHold_d = FlushLoad;
    end else if (flushHold_q != 2'd0) begin
      flushHold_d = flushHold_q - 2'd1;
    end
  end

  // Saturating event counters for stall and flush cycles.
  always_comb begin
    stallCount_d = stallCount_q;
    flushCount_d = flushCount_q;
    if (stall && (stallCount_q != 16'hFFFF)) begin
      stallCount_d = stallCount_q + 16'd1;
    end
    if (flush && (flushCount_q != 16'hFFFF)) begin
      flushCount_d = flushCount_q + 16'd1;
    end
  end

  // State registers; reset forgets all pending writes and clears counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= 2'd0;
      end
      flushHold_q  <= 2'd0;
      stallCount_q <= 16'd0;
      flushCount_q <= 16'd0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      flushHold_q  <= flushHold_d;
      stallCount_q <= stallCount_d;
      flushCount_q <= flushCount_d;
    end
  end

  assign stall_count = stallCount_q;
  assign flush_count = flushCount_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios for hazard_ctrl, with one instance
// using the default flush length and one holding flush two extra cycles.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_write_to_reg;
  logic [4:0]  id_dest;
  logic        ix_redirect;

  logic        stall, flush, issue;
  logic [31:0] busy_vec;
  logic [15:0] stall_count, flush_count;
  logic        stall2, flush2, issue2;
  logic [31:0] busyVec2;
  logic [15:0] stallCount2, flushCount2;

  int nChecks = 0;
  int nErrors = 0;

  hazard_ctrl #(.WB_DIST(3), .FLUSH_EXTRA(0)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_write_to_reg(id_write_to_reg), .id_dest(id_dest),
    .ix_redirect(ix_redirect), .stall(stall), .flush(flush), .issue(issue),
    .busy_vec(busy_vec), .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_ctrl #(.WB_DIST(3), .FLUSH_EXTRA(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_write_to_reg(id_write_to_reg), .id_dest(id_dest),
    .ix_redirect(ix_redirect), .stall(stall2), .flush(flush2), .issue(issue2),
    .busy_vec(busyVec2), .stall_count(stallCount2), .flush_count(flushCount2)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one ID/IX input vector and let combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [4:0] rs,
                               input logic [4:0] rt, input logic urs,
                               input logic urt, input logic wr,
                               input logic [4:0] dest, input logic redir);
    id_valid        = v;
    id_rs           = rs;
    id_rt           = rt;
    id_uses_rs      = urs;
    id_uses_rt      = urt;
    id_write_to_reg = wr;
    id_dest         = dest;
    ix_redirect     = redir;
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    nChecks++;
    if (busy_vec !== 32'd0) begin
      nErrors++; $display("[TB] FAIL reset_busy got=%h exp=0", busy_vec);
    end
    nChecks++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
      nErrors++; $display("[TB] FAIL reset_counts got=%0d/%0d exp=0/0", stall_count, flush_count);
    end
    applyStimulus(1, 5, 0, 1, 0, 0, 0, 0);
    nChecks++;
    if (stall !== 1'b0 || issue !== 1'b1) begin
      nErrors++; $display("[TB] FAIL reset_issue got stall=%b issue=%b exp 0/1", stall, issue);
    end
    step();
  endtask

  task automatic test_raw_stall();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 1, 5, 0);
    nChecks++;
    if (issue !== 1'b1) begin
      nErrors++; $display("[TB] FAIL raw_producer_issue got=%b exp=1", issue);
    end
    step();
    applyStimulus(1, 5, 0, 1, 0, 0, 0, 0);
    nChecks++;
    if (stall !== 1'b1 || issue !== 1'b0 || busy_vec[5] !== 1'b1) begin
      nErrors++; $display("[TB] FAIL raw_stall1 got stall=%b issue=%b busy=%b exp 1/0/1", stall, issue, busy_vec[5]);
    end
    step();
    nChecks++;
    if (stall !== 1'b1 || busy_vec[5] !== 1'b1) begin
      nErrors++; $display("[TB] FAIL raw_stall2 got stall=%b busy=%b exp 1/1", stall, busy_vec[5]);
    end
    step();
    nChecks++;
    if (stall !== 1'b0 || issue !== 1'b1 || busy_vec[5] !== 1'b0) begin
      nErrors++; $display("[TB] FAIL raw_release got stall=%b issue=%b busy=%b exp 0/1/0", stall, issue, busy_vec[5]);
    end
    nChecks++;
    if (stall_count !== 16'd2) begin
      nErrors++; $display("[TB] FAIL raw_stall_count got=%0d exp=2", stall_count);
    end
    step();
  endtask

  task automatic test_one_behind();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 1, 5, 0);
    step();
    applyStimulus(1, 1, 2, 1, 1, 0, 0, 0);
    nChecks++;
    if (issue !== 1'b1) begin
      nErrors++; $display("[TB] FAIL gap1_unrelated_issue got=%b exp=1", issue);
    end
    step();
    applyStimulus(1, 0, 5, 0, 1, 0, 0, 0);
    nChecks++;
    if (stall !== 1'b1) begin
      nErrors++; $display("[TB] FAIL gap1_stall got=%b exp=1", stall);
    end
    step();
    nChecks++;
    if (stall !== 1'b0 || issue !== 1'b1 || stall_count !== 16'd1) begin
      nErrors++; $display("[TB] FAIL gap1_release got stall=%b issue=%b cnt=%0d exp 0/1/1", stall, issue, stall_count);
    end
    step();
  endtask

  task automatic test_r0_and_mask();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);
    step();
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
    nChecks++;
    if (busy_vec !== 32'd0 || stall !== 1'b0 || issue !== 1'b1) begin
      nErrors++; $display("[TB] FAIL r0_write got busy=%h stall=%b issue=%b exp 0/0/1", busy_vec, stall, issue);
    end
    applyStimulus(1, 0, 0, 0, 0, 1, 7, 0);
    step();
    applyStimulus(1, 7, 7, 0, 0, 0, 0, 0);
    nChecks++;
    if (busy_vec !== 32'h0000_0080 || stall !== 1'b0 || issue !== 1'b1) begin
      nErrors++; $display("[TB] FAIL mask_uses got busy=%h stall=%b issue=%b exp 00000080/0/1", busy_vec, stall, issue);
    end
    applyStimulus(1, 0, 7, 0, 1, 0, 0, 0);
    nChecks++;
    if (stall !== 1'b1) begin
      nErrors++; $display("[TB] FAIL rt_hazard got=%b exp=1", stall);
    end
    step();
  endtask

  task automatic test_redirect();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 1, 5, 0);
    step();
    applyStimulus(1, 5, 0, 1, 0, 0, 0, 1);
    nChecks++;
    if (flush !== 1'b1 || stall !== 1'b0 || issue !== 1'b0) begin
      nErrors++; $display("[TB] FAIL redirect_same got flush=%b stall=%b issue=%b exp 1/0/0", flush, stall, issue);
    end
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nChecks++;
    if (flush !== 1'b0 || flush_count !== 16'd1 || stall_count !== 16'd0) begin
      nErrors++; $display("[TB] FAIL redirect_after got flush=%b fc=%0d sc=%0d exp 0/1/0", flush, flush_count, stall_count);
    end
    nChecks++;
    if (busy_vec[5] !== 1'b1) begin
      nErrors++; $display("[TB] FAIL redirect_keeps_sb got=%b exp=1", busy_vec[5]);
    end
    step();
    nChecks++;
    if (busy_vec[5] !== 1'b0) begin
      nErrors++; $display("[TB] FAIL redirect_sb_drain got=%b exp=0", busy_vec[5]);
    end
  endtask

  task automatic test_flush_extra();
    logic expFlush [5];
    expFlush = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    doReset();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, (c < 2) ? 1'b1 : 1'b0);
      nChecks++;
      if (flush2 !== expFlush[c]) begin
        nErrors++; $display("[TB] FAIL flush_extra_c%0d got=%b exp=%b", c, flush2, expFlush[c]);
      end
      step();
    end
    nChecks++;
    if (flushCount2 !== 16'd4 || flush_count !== 16'd2) begin
      nErrors++; $display("[TB] FAIL flush_counts got=%0d/%0d exp=4/2", flushCount2, flush_count);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 1, 9, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    nChecks++;
    if (busy_vec[9] !== 1'b1) begin
      nErrors++; $display("[TB] FAIL reload_pre got=%b exp=1", busy_vec[9]);
    end
    applyStimulus(1, 0, 0, 0, 0, 1, 9, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    nChecks++;
    if (busy_vec[9] !== 1'b1) begin
      nErrors++; $display("[TB] FAIL reload_hold got=%b exp=1", busy_vec[9]);
    end
    step();
    nChecks++;
    if (busy_vec[9] !== 1'b0) begin
      nErrors++; $display("[TB] FAIL reload_drain got=%b exp=0", busy_vec[9]);
    end
  endtask

  task automatic test_reset_mid_stall();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 1, 5, 0);
    step();
    applyStimulus(1, 5, 0, 1, 0, 0, 0, 0);
    nChecks++;
    if (stall !== 1'b1) begin
      nErrors++; $display("[TB] FAIL midrst_stall got=%b exp=1", stall);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    nChecks++;
    if (stall !== 1'b0 || issue !== 1'b1 || busy_vec !== 32'd0 || stall_count !== 16'd0) begin
      nErrors++; $display("[TB] FAIL midrst_release got stall=%b issue=%b busy=%h sc=%0d exp 0/1/0/0", stall, issue, busy_vec, stall_count);
    end
    step();
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_raw_stall();
    test_one_behind();
    test_r0_and_mask();
    test_redirect();
    test_flush_extra();
    test_back_to_back();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
